window_filter3x3_stream: RTL and testbench
==========================================

Name: window_filter3x3_stream

Overview:
- Parametrised 3x3 neighbourhood filter for the grayscale image path. Sits between the pixel frame store read side and the display frame store write side.
- Accepts one raster-order pixel stream per frame and emits one filtered pixel per input pixel, in the same raster order.
- Has internal line buffers, zero-padded borders, and a valid/ready handshake on both sides.
- Selects identity, Gaussian blur, thresholded Sobel edge, or saturated Sobel magnitude.

Parameters:
- IMG_W, 80, pixels per line (>=3).
- IMG_H, 80, lines per frame (>=3).
- PIX_W, 8, bits per grayscale pixel.
- THRESH, 127, edge threshold for mode 2 (compared with |Gx|+|Gy|).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  00 identity, 01 Gaussian, 10 Sobel threshold, 11 Sobel magnitude.
- s_valid  in  1  input pixel valid.
- s_data  in  PIX_W  input pixel.
- s_ready  out  1  input accepted when s_valid&&s_ready.
- m_valid  out  1  output pixel valid.
- m_data  out  PIX_W  filtered pixel.
- m_ready  in  1  downstream accept.
- m_sof  out  1  marks output pixel (0,0).
- m_last  out  1  marks output pixel (IMG_H-1, IMG_W-1).

Behaviour:
- Reset (async on rst_n low):
  - State FILL; all row/col counters 0.
  - m_valid=0, m_data=0, m_sof=0, m_last=0.
  - s_ready=1 once released.
  - Line-buffer contents are don't-care; padding is done by masking, not by clearing.
- Storage: two line buffers of IMG_W x PIX_W plus a 3x3 window register. Input counters in_col/in_row wrap at IMG_W/IMG_H.
- FSM:
  - FILL: accepts the first IMG_W+1 pixels of a frame; no output produced; s_ready=1. On the acceptance that makes the count IMG_W+1, go to RUN.
  - RUN: each accepted input produces the output centred one row up and one column left. s_ready = !m_valid || m_ready. After the final input pixel (IMG_H-1, IMG_W-1) is accepted, go to FLUSH.
  - FLUSH: s_ready=0. Generates IMG_W+1 internal zero-pad steps, one per cycle when the output register is free, to emit the remaining outputs. After the m_last handshake, go to FILL.
- Mode is sampled on acceptance of input pixel (0,0) and held for the whole frame; changes mid-frame are ignored.
- Latency: m_valid rises on the clock after the enabling input acceptance or flush step.
- Output register holds m_data, m_sof and m_last stable while m_valid && !m_ready.
- Padding:
  - Window taps outside the image (row<0, row>=IMG_H, col<0, col>=IMG_W) read as 0.
  - Line wrap never leaks pixels from the adjacent line.
- Arithmetic: signed, PIX_W+5 bits internally; no intermediate overflow.
  - Identity: centre tap.
  - Gaussian: kernel [1 2 1; 2 4 2; 1 2 1], sum >>4 (truncate).
  - Gx = (TR + 2MR + BR) - (TL + 2ML + BL).
  - Gy = (BL + 2BC + BR) - (TL + 2TC + TR).
  - S = |Gx| + |Gy|.
  - Mode 10: output all-ones if S > THRESH, else 0.
  - Mode 11: output min(S, 2^PIX_W - 1).
- Exactly IMG_W*IMG_H outputs per frame. m_sof is on the first output, m_last on the final one.
- A new frame's input is not accepted until m_last of the previous frame has handshaken.
- Simultaneous m_ready and a new result in RUN: the output register reloads in the same cycle, giving full throughput of 1 pixel/clk with no bubble.
- Reset mid-frame: all in-flight data is discarded; the next accepted pixel is treated as (0,0).

Test Plan:
- Identity, 4x4 (IMG_W=IMG_H=4), ramp 0..15, m_ready=1 → outputs 0..15 in order. m_sof on output 0, m_last on output 15. First m_valid one clock after the 6th input acceptance.
- Gaussian, 4x4 constant 100 → corners 56, non-corner edges 75, interior 100.
- Sobel threshold, 4x4, columns 0,0,200,200 on every row → interior rows: col0=0, col1=255, col2=255, col3=255. Rerun in mode 11 → interior col1 = 255 (800 saturated).
- Backpressure: m_ready toggled 1,0,0,1 repeatedly in identity mode → no lost or duplicated pixels; m_data stable while stalled; s_ready=0 whenever m_valid && !m_ready.
- Mode switched 00→01 after input pixel 5 → the entire frame is output as identity; the next frame is Gaussian.
- rst_n pulsed low mid-RUN → m_valid=0 immediately; state FILL; next frame output is correct and complete (16 pixels, m_sof first).

Source files
------------

// File: rtl/window_filter3x3_stream.sv
// window_filter3x3_stream
// 3x3 neighbourhood filter over a raster-order grayscale pixel stream.
// It emits one filtered pixel per input pixel, in the same raster order.
// Borders are zero-padded by masking window taps that fall outside the image.
//
// Ports:
//   clk      single clock
//   rst_n    asynchronous active-low reset
//   mode     00 identity, 01 Gaussian, 10 Sobel threshold, 11 Sobel magnitude
//            (sampled when input pixel (0,0) is accepted)
//   s_valid  input pixel valid
//   s_data   input pixel
//   s_ready  input pixel accepted when s_valid && s_ready
//   m_valid  output pixel valid
//   m_data   filtered pixel
//   m_ready  downstream accept
//   m_sof    marks output pixel (0,0)
//   m_last   marks output pixel (IMG_H-1, IMG_W-1)
module window_filter3x3_stream #(
  parameter int IMG_W  = 80,
  parameter int IMG_H  = 80,
  parameter int PIX_W  = 8,
  parameter int THRESH = 127
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             s_valid,
  input  logic [PIX_W-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [PIX_W-1:0] m_data,
  input  logic             m_ready,
  output logic             m_sof,
  output logic             m_last
);

  localparam int AW = PIX_W + 5;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 2);  // step row runs to IMG_H+1 while flushing

  localparam logic [CW-1:0]        COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]        ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0]        ROW_ONE  = RW'(1);
  localparam logic signed [AW-1:0] THRESH_A = AW'(THRESH);
  localparam logic signed [AW-1:0] MAX_A    = AW'((1 << PIX_W) - 1);
  localparam logic signed [AW-1:0] ZERO_A   = AW'(0);
  localparam logic [PIX_W-1:0]     ONES_P   = {PIX_W{1'b1}};
  localparam logic [PIX_W-1:0]     ZERO_P   = {PIX_W{1'b0}};

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                  state_r;
  logic [CW-1:0]           col_r;        // column of the current window step
  logic [RW-1:0]           row_r;        // row of the current window step
  logic [CW-1:0]           o_col_r;      // column of the next output pixel
  logic [RW-1:0]           o_row_r;      // row of the next output pixel
  logic [1:0]              mode_r;
  logic                    gen_done_r;   // last output of the frame generated
  logic [PIX_W-1:0]        lb0_r [IMG_W]; // row above the step row
  logic [PIX_W-1:0]        lb1_r [IMG_W]; // two rows above the step row
  // Left and centre window columns; the right column arrives with each step.
  logic [PIX_W-1:0]        win_r [3][2];

  logic                    out_free_s;
  logic                    accept_s;
  logic                    step_s;
  logic                    emit_s;
  logic [PIX_W-1:0]        pix_in_s;
  logic [PIX_W-1:0]        win_n_s [3][3];
  logic signed [AW-1:0]    tap_s [3][3];
  logic                    top_ok_s, bot_ok_s, left_ok_s, right_ok_s;
  logic                    o_first_s, o_last_s;
  logic signed [AW-1:0]    gauss_s, gx_s, gy_s, sob_s;
  logic [PIX_W-1:0]        res_s;

  function automatic logic signed [AW-1:0] ext_pix(input logic [PIX_W-1:0] p);
    return {{5{1'b0}}, p};
  endfunction

  function automatic logic signed [AW-1:0] abs_a(input logic signed [AW-1:0] v);
    return v[AW-1] ? -v : v;
  endfunction

  function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [AW-1:0] v);
    return (v > MAX_A) ? ONES_P : v[PIX_W-1:0];
  endfunction

  // Handshake qualifiers and window-step strobes per state.
  always_comb begin
    out_free_s = !m_valid || m_ready;
    s_ready    = 1'b0;
    step_s     = 1'b0;
    emit_s     = 1'b0;
    case (state_r)
      ST_FILL: begin
        s_ready = 1'b1;
        step_s  = s_valid;
      end
      ST_RUN: begin
        s_ready = out_free_s;
        step_s  = s_valid && out_free_s;
        emit_s  = s_valid && out_free_s;
      end
      ST_FLUSH: begin
        step_s = out_free_s && !gen_done_r;
        emit_s = out_free_s && !gen_done_r;
      end
      default: begin
        s_ready = 1'b0;
      end
    endcase
    accept_s = s_valid && s_ready;
    // Flush steps push zero pixels; those rows are masked anyway.
    if (state_r == ST_FLUSH) begin
      pix_in_s = ZERO_P;
    end else begin
      pix_in_s = s_data;
    end
  end

  // Window as seen after this step: stored columns plus the incoming column.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_n_s[r][0] = win_r[r][0];
      win_n_s[r][1] = win_r[r][1];
    end
    win_n_s[0][2] = lb1_r[col_r];
    win_n_s[1][2] = lb0_r[col_r];
    win_n_s[2][2] = pix_in_s;
  end

  // Border masking around the output centre; also hides line-wrap columns.
  always_comb begin
    top_ok_s   = (o_row_r != {RW{1'b0}});
    bot_ok_s   = (o_row_r != ROW_LAST);
    left_ok_s  = (o_col_r != {CW{1'b0}});
    right_ok_s = (o_col_r != COL_LAST);
    o_first_s  = !top_ok_s && !left_ok_s;
    o_last_s   = !bot_ok_s && !right_ok_s;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        tap_s[r][c] = ZERO_A;
        if ((r == 0 && !top_ok_s) || (r == 2 && !bot_ok_s) ||
            (c == 0 && !left_ok_s) || (c == 2 && !right_ok_s)) begin
          tap_s[r][c] = ZERO_A;
        end else begin
          tap_s[r][c] = ext_pix(win_n_s[r][c]);
        end
      end
    end
  end

  // Kernel arithmetic and mode selection.
  always_comb begin
    gauss_s = tap_s[0][0] + (tap_s[0][1] <<< 1'b1) + tap_s[0][2]
            + (tap_s[1][0] <<< 1'b1) + (tap_s[1][1] <<< 2'd2) + (tap_s[1][2] <<< 1'b1)
            + tap_s[2][0] + (tap_s[2][1] <<< 1'b1) + tap_s[2][2];
    gx_s = (tap_s[0][2] + (tap_s[1][2] <<< 1'b1) + tap_s[2][2])
         - (tap_s[0][0] + (tap_s[1][0] <<< 1'b1) + tap_s[2][0]);
    gy_s = (tap_s[2][0] + (tap_s[2][1] <<< 1'b1) + tap_s[2][2])
         - (tap_s[0][0] + (tap_s[0][1] <<< 1'b1) + tap_s[0][2]);
    sob_s = abs_a(gx_s) + abs_a(gy_s);
    res_s = ZERO_P;
    case (mode_r)
      2'b00: res_s = clamp_pix(tap_s[1][1]);
      2'b01: res_s = clamp_pix(gauss_s >>> 3'd4);
      2'b10: begin
        if (sob_s > THRESH_A) begin
          res_s = ONES_P;
        end else begin
          res_s = ZERO_P;
        end
      end
      2'b11: res_s = clamp_pix(sob_s);
      default: res_s = ZERO_P;
    endcase
  end

  // Line buffers: contents need no reset because out-of-image taps are masked.
  always_ff @(posedge clk) begin
    if (step_s) begin
      lb1_r[col_r] <= lb0_r[col_r];
      lb0_r[col_r] <= pix_in_s;
    end
  end

  // Window column shift on every step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        win_r[r][0] <= ZERO_P;
        win_r[r][1] <= ZERO_P;
      end
    end else if (step_s) begin
      for (int r = 0; r < 3; r++) begin
        win_r[r][0] <= win_n_s[r][1];
        win_r[r][1] <= win_n_s[r][2];
      end
    end
  end

  // Frame FSM, step/output counters and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_FILL;
      col_r      <= {CW{1'b0}};
      row_r      <= {RW{1'b0}};
      o_col_r    <= {CW{1'b0}};
      o_row_r    <= {RW{1'b0}};
      mode_r     <= 2'b00;
      gen_done_r <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= ZERO_P;
      m_sof      <= 1'b0;
      m_last     <= 1'b0;
    end else begin
      if (step_s) begin
        if (col_r == COL_LAST) begin
          col_r <= {CW{1'b0}};
          row_r <= row_r + RW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
      end
      // Reloading while m_ready is high gives back-to-back outputs.
      if (emit_s) begin
        m_valid <= 1'b1;
        m_data  <= res_s;
        m_sof   <= o_first_s;
        m_last  <= o_last_s;
        if (o_col_r == COL_LAST) begin
          o_col_r <= {CW{1'b0}};
          o_row_r <= (o_row_r == ROW_LAST) ? {RW{1'b0}} : o_row_r + RW'(1);
        end else begin
          o_col_r <= o_col_r + CW'(1);
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_sof   <= 1'b0;
        m_last  <= 1'b0;
      end
      case (state_r)
        ST_FILL: begin
          if (accept_s) begin
            if (row_r == {RW{1'b0}} && col_r == {CW{1'b0}}) begin
              mode_r <= mode;
            end
            // Pixel (1,0) is the IMG_W+1-th of the frame.
            if (row_r == ROW_ONE && col_r == {CW{1'b0}}) begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (accept_s && row_r == ROW_LAST && col_r == COL_LAST) begin
            state_r <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (emit_s && o_last_s) begin
            gen_done_r <= 1'b1;
          end
          if (m_valid && m_ready && m_last) begin
            state_r    <= ST_FILL;
            row_r      <= {RW{1'b0}};
            col_r      <= {CW{1'b0}};
            gen_done_r <= 1'b0;
          end
        end
        default: state_r <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_window_filter3x3_stream.sv
// Testbench for window_filter3x3_stream on a 4x4 image: directed and random
// frames in every mode, compared against a 2-D arithmetic reference model.
module tb_window_filter3x3_stream;

  localparam int W = 4;
  localparam int H = 4;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b1;
  logic       m_sof;
  logic       m_last;

  always #5 clk = ~clk;

  window_filter3x3_stream #(
    .IMG_W(W), .IMG_H(H), .PIX_W(8), .THRESH(127)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .m_sof(m_sof), .m_last(m_last)
  );

  typedef struct {
    int data;
    bit sof;
    bit last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   img[NPIX];
  int   n_checks = 0;
  int   n_errors = 0;
  int   bp_kind = 0;
  int   cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int px(int r, int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return img[r * W + c];
  endfunction

  function automatic int ref_pix(int md, int r, int c);
    int sum, gx, gy, s, wr;
    sum = 0; gx = 0; gy = 0;
    for (int d = -1; d <= 1; d++) begin
      wr = (d == 0) ? 2 : 1;
      gx += wr * (px(r + d, c + 1) - px(r + d, c - 1));
      gy += wr * (px(r + 1, c + d) - px(r - 1, c + d));
      for (int e = -1; e <= 1; e++) sum += wr * ((e == 0) ? 2 : 1) * px(r + d, c + e);
    end
    s = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    case (md)
      0: return px(r, c);
      1: return sum / 16;
      2: return (s > 127) ? 255 : 0;
      3: return (s > 255) ? 255 : s;
      default: return 0;
    endcase
  endfunction

  task automatic fill_img(input int kind);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0: img[i] = i;
        1: img[i] = 100;
        2: img[i] = ((i % W) >= 2) ? 200 : 0;
        3: img[i] = $urandom_range(0, 255);
        default: img[i] = ($urandom_range(0, 1) == 1) ? 255 : 0;
      endcase
    end
  endtask

  // One clock: advance past the edge, then set m_ready for the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (bp_kind)
      1: m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2: m_ready = ($urandom_range(0, 1) == 1);
      default: m_ready = 1'b1;
    endcase
  endtask

  task automatic feed_frame(input int md, input int kind, input int sw_mode,
                            input int npix, input bit lat_chk, input bit gaps);
    bit acc;
    int budget;
    fill_img(kind);
    mode = md[1:0];
    for (int i = 0; i < NPIX; i++)
      sb.push_back('{ref_pix(md, i / W, i % W), (i == 0), (i == NPIX - 1)});
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        tick();
      end
      s_valid = 1'b1;
      s_data  = img[i][7:0];
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 200) begin
        @(negedge clk);
        acc = s_ready;
        tick();
        budget++;
      end
      if (!acc) check_val("in_timeout", 0, 1);
      if (lat_chk && i == 4) check_val("lat_pre", m_valid, 0);
      if (lat_chk && i == 5) check_val("lat_first", m_valid, 1);
      if (i == 5 && sw_mode >= 0) mode = sw_mode[1:0];
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() > 0 && budget < 2000) begin
      tick();
      budget++;
    end
    check_val("drain_empty", sb.size(), 0);
  endtask

  // Output monitor: scoreboard compare, stall hold and input backpressure.
  bit         stall_p = 1'b0;
  logic [7:0] d_p;
  logic       sof_p, last_p;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_p) begin
        check_val("hold_valid", m_valid, 1);
        check_val("hold_data", m_data, d_p);
        check_val("hold_sof", m_sof, sof_p);
        check_val("hold_last", m_last, last_p);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check_val("extra_out", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check_val("data", m_data, mon_e.data);
          check_val("sof", m_sof, mon_e.sof);
          check_val("last", m_last, mon_e.last);
        end
      end
      if (m_valid && !m_ready) begin
        check_val("s_ready_stall", s_ready, 0);
        stall_p = 1'b1;
        d_p = m_data;
        sof_p = m_sof;
        last_p = m_last;
      end else begin
        stall_p = 1'b0;
      end
    end else begin
      stall_p = 1'b0;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_m_data", m_data, 0);
    check_val("rst_m_sof", m_sof, 0);
    check_val("rst_m_last", m_last, 0);
    rst_n = 1'b1;
    #1;
    check_val("rst_s_ready", s_ready, 1);

    // Directed frames from the test plan, full throughput.
    feed_frame(0, 0, -1, NPIX, 1'b1, 1'b0);
    feed_frame(1, 1, -1, NPIX, 1'b0, 1'b0);
    feed_frame(2, 2, -1, NPIX, 1'b0, 1'b0);
    feed_frame(3, 2, -1, NPIX, 1'b0, 1'b0);
    // Backpressure 1,0,0,1.
    bp_kind = 1;
    feed_frame(0, 0, -1, NPIX, 1'b0, 1'b0);
    feed_frame(0, 3, -1, NPIX, 1'b0, 1'b0);
    // Mid-frame mode change is ignored; next frame picks it up.
    bp_kind = 0;
    feed_frame(0, 3, 1, NPIX, 1'b0, 1'b0);
    feed_frame(1, 3, -1, NPIX, 1'b0, 1'b0);
    // Random data, random m_ready, input gaps, every mode.
    bp_kind = 2;
    for (int k = 0; k < 8; k++) feed_frame(k % 4, 3 + (k / 4), -1, NPIX, 1'b0, 1'b1);
    bp_kind = 0;
    drain();

    // Reset in the middle of a frame, then a full clean frame.
    feed_frame(0, 0, -1, 10, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_val("midrst_m_valid", m_valid, 0);
    check_val("midrst_s_ready", s_ready, 1);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    feed_frame(0, 3, -1, NPIX, 1'b1, 1'b0);
    drain();
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
